mem_read_arbiter: RTL and testbench
===================================

# mem_read_arbiter

Shares one word-wide memory read port between `NUM_REQ` chunk processors so several SHA-256 contexts can fill chunks concurrently. Each requester is granted the port for up to one chunk's worth of addresses, chosen round-robin. Read responses return in order. The block tracks which requester owns each outstanding read and steers the returning data to it.

## Interface
Parameters:
- `NUM_REQ`, 4, number of chunk processor requesters (2..8)
- `MAX_OUTSTANDING`, 8, maximum in-flight reads; power of two
- `BURST_WORDS`, 16, maximum addresses per grant (one 64-byte chunk)

Ports:
- Clocking and reset (already decided):
  - `clk`  in  1  single clock
  - `rst`  in  1  asynchronous, active-high reset
- Requester side:
  - `req_addr_vld`  in  `NUM_REQ`  per-requester address valid
  - `req_addr`  in  `NUM_REQ`x32  per-requester byte address
  - `req_addr_rdy`  out  `NUM_REQ`  address accepted this cycle (one-hot or zero)
  - `req_data_vld`  out  `NUM_REQ`  read data valid for that requester (one-hot or zero)
  - `req_data`  out  32  read data, broadcast to all requesters
- Memory side:
  - `mem_addr_vld`  out  1  address valid to memory
  - `mem_addr`  out  32  address to memory
  - `mem_addr_rdy`  in  1  memory accepts address
  - `mem_data_vld`  in  1  in-order read response valid
  - `mem_data`  in  32  read response data
- Status:
  - `busy`  out  1  grant active or reads outstanding
  - `err`  out  1  sticky: response arrived with no outstanding read

## Operation
State machine, states `ARB` and `GRANT`:
- `ARB`: if any `req_addr_vld` is set, pick the first set bit scanning upward from `last_grant+1` (mod `NUM_REQ`). Register it as `grant_id`, clear `burst_cnt`, go to `GRANT`. With no request, stay in `ARB`.
- `GRANT`: the address path is a combinational pass-through from requester `grant_id`:
  - `mem_addr_vld = req_addr_vld[grant_id] & (outstanding < MAX_OUTSTANDING)`
  - `mem_addr = req_addr[grant_id]`
  - `req_addr_rdy[grant_id] = mem_addr_vld & mem_addr_rdy`
- Accept: an accept is `mem_addr_vld & mem_addr_rdy`. Each accept pushes `grant_id` into the tag FIFO and increments `burst_cnt`.
- Leave `GRANT` for `ARB` when either:
  - an accept makes `burst_cnt == BURST_WORDS`, or
  - `req_addr_vld[grant_id]` is low.
  - On exit, `last_grant <= grant_id`.
- Return path:
  - `req_data = mem_data`.
  - `req_data_vld[fifo_head] = mem_data_vld` when the FIFO is non-empty; the FIFO pops on that same cycle.
- Outstanding count (`$clog2(MAX_OUTSTANDING)+1` bits): +1 on accept, -1 on a valid pop. Simultaneous push and pop leaves the count unchanged.
- `mem_data_vld` with an empty FIFO: data is dropped, all `req_data_vld` stay 0, and `err` is set. `err` clears only on `rst`.
- `busy = (state == GRANT) | (outstanding != 0)`.

## Timing
- Reset values:
  - `state = ARB`, `last_grant = NUM_REQ-1` (so requester 0 wins first), `burst_cnt = 0`, FIFO empty, `outstanding = 0`, `err = 0`.
  - All outputs 0.
- Arbitration costs one cycle: a request seen in `ARB` at edge N can be accepted at earliest in cycle N+1.
- Address and data paths have zero added latency (combinational). `req_data_vld` follows `mem_data_vld` in the same cycle.
- A requester must hold `req_addr_vld` and `req_addr` stable until `req_addr_rdy`.
- When `outstanding == MAX_OUTSTANDING`, `mem_addr_vld` is low and the grant is held. Stalling on credit does not end the burst.
- Reset mid-operation: all tracking is lost. Responses that arrive after reset set `err`. Memory must be reset together with this block.

## Structure
- `sha256_pkg` additions: `MemArbState` enum (`ARB`, `GRANT`) and `MEM_ARB_BURST_WORDS = BYTES_IN_CHUNK / MEM_WORD_BYTES`.
- Sub-module `mem_tag_fifo`:
  - sync FIFO, depth `MAX_OUTSTANDING`, width `$clog2(NUM_REQ)`, async reset
  - push/pop/full/empty ports; simultaneous push and pop allowed when full or empty
- The round-robin pick is a function inside this block.

## Test plan
- Single requester 0 issues 16 addresses from 0x1000 step 4, memory latency 3, `mem_addr_rdy = 1` → 16 accepts in cycles 1–16, 16 `req_data_vld[0]` pulses in order, then `state = ARB` and `busy = 0` after the last response.
- Requesters 1 and 2 assert together from reset → 1 is granted first for 16 words, one `ARB` cycle, then 2. All responses are steered by tag with no cross-delivery.
- `MAX_OUTSTANDING = 8`, memory holds responses for 20 cycles → exactly 8 accepts, then `mem_addr_vld = 0`. After each response one new accept occurs, and the grant is held throughout.
- Requester 3 drops `req_addr_vld` after 5 words → `GRANT` exits and requester 0 (pending) is granted next. `last_grant = 3`.
- `mem_data_vld` pulse with nothing outstanding → `err = 1`, no `req_data_vld`. `err` stays 1 until `rst`.
- `rst` asserted mid-burst with 4 reads outstanding → all outputs 0 immediately. After release, requester 0 is granted first.

Source files
------------

// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the chunk-fill memory read arbiter.
// A burst covers exactly one SHA-256 chunk of memory words.
package mem_read_arbiter_pkg;

  localparam int DATA_W              = 32;
  localparam int BYTES_IN_CHUNK      = 64;
  localparam int MEM_WORD_BYTES      = DATA_W / 8;
  localparam int MEM_ARB_BURST_WORDS = BYTES_IN_CHUNK / MEM_WORD_BYTES;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } MemArbState;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Requester and memory-side signals of the read arbiter.
// master = the arbiter itself, slave = the requesters plus the memory.
interface mem_read_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import mem_read_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             req_addr_vld;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_addr_rdy;
  logic [NUM_REQ-1:0]             req_data_vld;
  logic [DATA_W-1:0]              req_data;
  logic                           mem_addr_vld;
  logic [DATA_W-1:0]              mem_addr;
  logic                           mem_addr_rdy;
  logic                           mem_data_vld;
  logic [DATA_W-1:0]              mem_data;

  modport master (
    input  req_addr_vld, req_addr, mem_addr_rdy, mem_data_vld, mem_data,
    output req_addr_rdy, req_data_vld, req_data, mem_addr_vld, mem_addr
  );

  modport slave (
    output req_addr_vld, req_addr, mem_addr_rdy, mem_data_vld, mem_data,
    input  req_addr_rdy, req_data_vld, req_data, mem_addr_vld, mem_addr
  );

endinterface

// File: rtl/mem_tag_fifo.sv
// Synchronous FIFO holding the requester id of each in-flight read.
// Storage is not reset; only pointers and occupancy are.
module mem_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one in-order memory read port between chunk
// processors; a tag FIFO steers each returning word to its requester.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BURST_WORDS     = MEM_ARB_BURST_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  mem_read_arbiter_if.master  bus,
  output logic                busy,
  output logic                err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BC_W  = $clog2(BURST_WORDS + 1);

  MemArbState       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d, last_q, last_d;
  logic [BC_W-1:0]  burst_q, burst_d, burst_inc;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             accept, pop, credit_ok;
  logic             fifo_full, fifo_empty;
  logic [ID_W-1:0]  fifo_head;

  // First requesting index strictly after `last`, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last) + i) % NUM_REQ);
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign credit_ok = (out_q < OUT_W'(MAX_OUTSTANDING)) & ~fifo_full;
  assign burst_inc = burst_q + BC_W'(1);

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    burst_d          = burst_q;
    accept           = 1'b0;
    bus.mem_addr_vld = 1'b0;
    bus.mem_addr     = '0;
    bus.req_addr_rdy = '0;
    case (state_q)
      ARB: begin
        if (|bus.req_addr_vld) begin
          grant_d = rr_pick(bus.req_addr_vld, last_q);
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bus.mem_addr_vld          = bus.req_addr_vld[grant_q] & credit_ok;
        bus.mem_addr              = bus.req_addr[grant_q];
        accept                    = bus.mem_addr_vld & bus.mem_addr_rdy;
        bus.req_addr_rdy[grant_q] = accept;
        if (accept) burst_d = burst_inc;
        // A credit stall keeps the grant; only a full burst or a dropped request ends it.
        if ((accept && (burst_inc == BC_W'(BURST_WORDS))) || !bus.req_addr_vld[grant_q]) begin
          state_d = ARB;
          last_d  = grant_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign pop          = bus.mem_data_vld & ~fifo_empty;
  assign bus.req_data = bus.mem_data;
  assign err_d        = err_q | (bus.mem_data_vld & fifo_empty);
  assign busy         = (state_q == GRANT) | (out_q != '0);
  assign err          = err_q;

  always_comb begin
    bus.req_data_vld = '0;
    if (pop) bus.req_data_vld[fifo_head] = 1'b1;
  end

  always_comb begin
    out_d = out_q;
    case ({accept, pop})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      burst_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  mem_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_data_i (grant_q),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: requester/memory models in one process,
// directed test steps with hand-derived cycle expectations in another.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  mem_read_arbiter_if #(.NUM_REQ(NR)) bus ();

  mem_read_arbiter #(
    .NUM_REQ         (NR),
    .MAX_OUTSTANDING (8),
    .BURST_WORDS     (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int arb_cycles = 0;
  int want [NR];
  int acc_cnt [NR];
  int resp_cnt [NR];
  int first_acc [NR];
  int last_acc [NR];
  int drive_cyc [NR];
  logic [31:0] cur_addr [NR];
  logic [31:0] resp_next [NR];
  logic hold = 1'b0;
  logic inject = 1'b0;
  logic [31:0] pend_addr [$];
  int pend_due [$];
  int resp_owner = -1;
  int own;
  logic [NR-1:0] exp_vld, exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester r owns byte addresses 0x1000*(r+1) upward.
  function automatic int owner_of(input logic [31:0] a);
    return int'(a[15:12]) - 1;
  endfunction

  function automatic int want_total();
    int s = 0;
    for (int r = 0; r < NR; r++) s += want[r];
    return s;
  endfunction

  task automatic clr_stats();
    for (int r = 0; r < NR; r++) begin
      acc_cnt[r]   = 0;
      resp_cnt[r]  = 0;
      first_acc[r] = -1;
      last_acc[r]  = -1;
    end
    arb_cycles = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst    = 1'b1;
    hold   = 1'b0;
    inject = 1'b0;
    for (int r = 0; r < NR; r++) want[r] = 0;
    #1;
    chk("rst_mem_addr_vld", 32'(bus.mem_addr_vld), 32'd0);
    chk("rst_req_addr_rdy", 32'(bus.req_addr_rdy), 32'd0);
    chk("rst_req_data_vld", 32'(bus.req_data_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while ((busy !== 1'b0 || want_total() != 0 || pend_addr.size() != 0) && k < 500);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_drained"}, 32'(want_total()), 32'd0);
  endtask

  task automatic wait_acc(input int r, input int n, input string tag);
    int k = 0;
    while (acc_cnt[r] < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, 32'(acc_cnt[r] >= n), 32'd1);
  endtask

  // Requester and memory models; also checks every response and address handshake.
  initial begin
    for (int r = 0; r < NR; r++) begin
      want[r]      = 0;
      cur_addr[r]  = 32'h1000 * 32'(r + 1);
      resp_next[r] = cur_addr[r];
      drive_cyc[r] = 0;
    end
    clr_stats();
    bus.req_addr_vld = '0;
    bus.req_addr     = '0;
    bus.mem_addr_rdy = 1'b1;
    bus.mem_data_vld = 1'b0;
    bus.mem_data     = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int r = 0; r < NR; r++) begin
        if (want[r] > 0 && !bus.req_addr_vld[r]) drive_cyc[r] = cyc;
        bus.req_addr_vld[r] = (want[r] > 0);
        bus.req_addr[r]     = cur_addr[r];
      end
      resp_owner       = -1;
      bus.mem_data_vld = 1'b0;
      if (!rst && inject) begin
        bus.mem_data_vld = 1'b1;
        bus.mem_data     = 32'hDEAD_BEEF;
        inject           = 1'b0;
      end else if (!rst && !hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus.mem_data_vld = 1'b1;
        bus.mem_data     = ~pend_addr[0];
        resp_owner       = owner_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      @(negedge clk);
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        for (int r = 0; r < NR; r++) resp_next[r] = cur_addr[r];
      end else begin
        exp_vld = (resp_owner >= 0) ? (NR'(1) << resp_owner) : '0;
        chk("req_data_vld", 32'(bus.req_data_vld), 32'(exp_vld));
        if (resp_owner >= 0) begin
          chk("req_data", bus.req_data, ~resp_next[resp_owner]);
          resp_next[resp_owner] = resp_next[resp_owner] + 32'd4;
          resp_cnt[resp_owner]++;
        end
        exp_rdy = '0;
        if (bus.mem_addr_vld && bus.mem_addr_rdy) begin
          own = owner_of(bus.mem_addr);
          if (own >= 0 && own < NR) exp_rdy = NR'(1) << own;
          pend_addr.push_back(bus.mem_addr);
          pend_due.push_back(cyc + LAT);
        end
        chk("req_addr_rdy", 32'(bus.req_addr_rdy), 32'(exp_rdy));
        if (dut.state_q == ARB && bus.req_addr_vld != '0) arb_cycles++;
        for (int r = 0; r < NR; r++) begin
          if (bus.req_addr_rdy[r]) begin
            acc_cnt[r]++;
            if (first_acc[r] < 0) first_acc[r] = cyc;
            last_acc[r] = cyc;
            cur_addr[r] = cur_addr[r] + 32'd4;
            want[r]--;
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // Single requester, full 16-word burst, latency 3.
    clr_stats();
    want[0] = 16;
    wait_idle("t1");
    chk("t1_first_acc", 32'(first_acc[0]), 32'(drive_cyc[0] + 1));
    chk("t1_last_acc", 32'(last_acc[0]), 32'(drive_cyc[0] + 16));
    chk("t1_acc_cnt", 32'(acc_cnt[0]), 32'd16);
    chk("t1_resp_cnt", 32'(resp_cnt[0]), 32'd16);
    chk("t1_state", 32'(dut.state_q), 32'(ARB));
    chk("t1_arb_cycles", 32'(arb_cycles), 32'd1);

    // Requesters 1 and 2 together from reset: 1 first, one ARB cycle, then 2.
    do_reset();
    clr_stats();
    want[1] = 16;
    want[2] = 16;
    wait_idle("t2");
    chk("t2_first_acc1", 32'(first_acc[1]), 32'(drive_cyc[1] + 1));
    chk("t2_last_acc1", 32'(last_acc[1]), 32'(drive_cyc[1] + 16));
    chk("t2_first_acc2", 32'(first_acc[2]), 32'(drive_cyc[1] + 18));
    chk("t2_last_acc2", 32'(last_acc[2]), 32'(drive_cyc[1] + 33));
    chk("t2_resp_cnt1", 32'(resp_cnt[1]), 32'd16);
    chk("t2_resp_cnt2", 32'(resp_cnt[2]), 32'd16);
    chk("t2_arb_cycles", 32'(arb_cycles), 32'd2);

    // Memory withholds responses: credit limit of 8, grant held throughout.
    @(posedge clk); #2;
    clr_stats();
    hold    = 1'b1;
    want[0] = 16;
    repeat (12) @(negedge clk);
    #1;
    chk("t3_acc_at_limit", 32'(acc_cnt[0]), 32'd8);
    chk("t3_mem_addr_vld", 32'(bus.mem_addr_vld), 32'd0);
    chk("t3_state_held", 32'(dut.state_q), 32'(GRANT));
    chk("t3_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    wait_idle("t3");
    chk("t3_acc_cnt", 32'(acc_cnt[0]), 32'd16);
    chk("t3_resp_cnt", 32'(resp_cnt[0]), 32'd16);
    chk("t3_arb_cycles", 32'(arb_cycles), 32'd1);

    // Requester 3 drops after 5 words, pending requester 0 follows.
    @(posedge clk); #2;
    clr_stats();
    want[3] = 5;
    want[0] = 16;
    wait_acc(0, 1, "t4_wait_req0");
    chk("t4_last_grant", 32'(dut.last_q), 32'd3);
    wait_idle("t4");
    chk("t4_first_acc3", 32'(first_acc[3]), 32'(drive_cyc[3] + 1));
    chk("t4_last_acc3", 32'(last_acc[3]), 32'(drive_cyc[3] + 5));
    chk("t4_first_acc0", 32'(first_acc[0]), 32'(drive_cyc[3] + 8));
    chk("t4_acc_cnt3", 32'(acc_cnt[3]), 32'd5);
    chk("t4_acc_cnt0", 32'(acc_cnt[0]), 32'd16);
    chk("t4_resp_cnt3", 32'(resp_cnt[3]), 32'd5);
    chk("t4_err_clear", 32'(err), 32'd0);

    // Spurious response with nothing outstanding sets sticky err.
    @(posedge clk); #2;
    inject = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_err_sticky", 32'(err), 32'd1);
    do_reset();

    // Reset mid-burst with 4 reads outstanding, then requester 0 wins first.
    clr_stats();
    hold    = 1'b1;
    want[0] = 16;
    wait_acc(0, 4, "t6_wait_4");
    chk("t6_busy_before", 32'(busy), 32'd1);
    do_reset();
    clr_stats();
    want[0] = 2;
    want[1] = 2;
    wait_idle("t6");
    chk("t6_first_acc0", 32'(first_acc[0]), 32'(drive_cyc[0] + 1));
    chk("t6_first_acc1", 32'(first_acc[1]), 32'(drive_cyc[0] + 5));
    chk("t6_resp_cnt0", 32'(resp_cnt[0]), 32'd2);
    chk("t6_resp_cnt1", 32'(resp_cnt[1]), 32'd2);
    chk("t6_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
